// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Turns a watchdog trip request into a clean, stretched reset pulse for
// downstream logic. Each accepted event holds sys_rst high for HOLD_CYCLES
// clocks and then waits SETTLE_CYCLES quiet clocks before another event can
// be accepted. After MAX_RESETS events without a software clear the block
// parks in LOCKOUT with sys_rst held high until clear_lockout is seen.
//
// Parameters
//   HOLD_CYCLES    1..65535  clocks of sys_rst per event
//   SETTLE_CYCLES  1..65535  quiet clocks after release
//   MAX_RESETS     1..255    event count that forces lockout
//
// Ports
//   clk            in   clock, whole block is in this domain
//   rst            in   asynchronous active-high reset
//   enable         in   allows new events to be accepted while idle
//   force_reset    in   trip request, only its rising edge matters
//   clear_lockout  in   software acknowledge: clears count / leaves lockout
//   sys_rst        out  registered stretched reset to downstream logic
//   rst_done       out  one-cycle pulse when a sequence returns to idle
//   busy           out  high while asserting or settling
//   lockout        out  high while locked out
//   reset_count    out  accepted events since last clear, saturates at 255
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_RESETS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       force_reset,
  input  logic       clear_lockout,
  output logic       sys_rst,
  output logic       rst_done,
  output logic       busy,
  output logic       lockout,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // The timer counts down to zero inclusive, so a phase of N cycles loads N-1.
  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  MAX_COUNT   = 8'(MAX_RESETS);
  localparam logic [7:0]  COUNT_SAT   = 8'hFF;

  state_t      state_reg,    state_next;
  logic [15:0] timer_reg,    timer_next;
  logic [7:0]  count_reg,    count_next;
  logic        force_q_reg;
  logic        sys_rst_reg,  sys_rst_next;
  logic        rst_done_reg, rst_done_next;
  logic        busy_reg,     busy_next;
  logic        lockout_reg,  lockout_next;

  logic        trigger;
  logic [7:0]  count_base;

  // Edge detect on the trip request. force_q_reg keeps tracking in every
  // state, so a level that is still high when the block returns to idle does
  // not look like a fresh edge.
  assign trigger = force_reset & ~force_q_reg & enable & (state_reg == ST_IDLE);

  // A clear in idle takes effect before a coincident trigger is counted.
  assign count_base = clear_lockout ? 8'd0 : count_reg;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    count_next    = count_reg;
    rst_done_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        count_next = count_base;
        if (trigger) begin
          state_next = ST_ASSERT;
          timer_next = HOLD_LOAD;
          count_next = (count_base == COUNT_SAT) ? COUNT_SAT : count_base + 8'd1;
        end
      end

      ST_ASSERT: begin
        if (timer_reg == 16'd0) begin
          state_next = ST_SETTLE;
          timer_next = SETTLE_LOAD;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end

      ST_SETTLE: begin
        if (timer_reg == 16'd0) begin
          if (count_reg >= MAX_COUNT) begin
            state_next = ST_LOCKOUT;
          end else begin
            state_next    = ST_IDLE;
            rst_done_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end

      ST_LOCKOUT: begin
        // Leaving lockout still goes through a full settle window so the
        // downstream logic sees a clean release before the next event.
        if (clear_lockout) begin
          state_next = ST_SETTLE;
          timer_next = SETTLE_LOAD;
          count_next = 8'd0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        timer_next = 16'd0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so sys_rst
    // rises on the same edge that samples the trigger.
    sys_rst_next = (state_next == ST_ASSERT) || (state_next == ST_LOCKOUT);
    busy_next    = (state_next == ST_ASSERT) || (state_next == ST_SETTLE);
    lockout_next = (state_next == ST_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= 16'd0;
      count_reg    <= 8'd0;
      // Starts high so a request held across reset release is not an edge.
      force_q_reg  <= 1'b1;
      sys_rst_reg  <= 1'b0;
      rst_done_reg <= 1'b0;
      busy_reg     <= 1'b0;
      lockout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      count_reg    <= count_next;
      force_q_reg  <= force_reset;
      sys_rst_reg  <= sys_rst_next;
      rst_done_reg <= rst_done_next;
      busy_reg     <= busy_next;
      lockout_reg  <= lockout_next;
    end
  end

  assign sys_rst     = sys_rst_reg;
  assign rst_done    = rst_done_reg;
  assign busy        = busy_reg;
  assign lockout     = lockout_reg;
  assign reset_count = count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       force_reset;
  logic       clear_lockout;
  logic       sys_rst;
  logic       rst_done;
  logic       busy;
  logic       lockout;
  logic [7:0] reset_count;

  int check_count = 0;
  int error_count = 0;

  // Status vector layout: {sys_rst, busy, rst_done, lockout}
  localparam logic [3:0] S_QUIET = 4'b0000;
  localparam logic [3:0] S_HOLD  = 4'b1100;
  localparam logic [3:0] S_WAIT  = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b0010;
  localparam logic [3:0] S_LOCK  = 4'b1001;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES  (16),
    .SETTLE_CYCLES(8),
    .MAX_RESETS   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .force_reset  (force_reset),
    .clear_lockout(clear_lockout),
    .sys_rst      (sys_rst),
    .rst_done     (rst_done),
    .busy         (busy),
    .lockout      (lockout),
    .reset_count  (reset_count)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller raises force_reset (and optionally clear_lockout) at a negedge;
  // the following posedge is trigger edge N. Step k is sampled after edge N+k.
  task automatic run_seq(input string name, input logic [7:0] exp_cnt, input bit to_lockout,
                         input int release_at, input int pulse_at,
                         input int drop_enable_at, input int clear_at);
    logic [3:0] exp;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      if (k < 16)       exp = S_HOLD;
      else if (k < 24)  exp = S_WAIT;
      else if (k == 24) exp = to_lockout ? S_LOCK : S_DONE;
      else              exp = to_lockout ? S_LOCK : S_QUIET;
      check_value($sformatf("%s_k%0d", name, k), {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, exp});
      if (k == 0) check_value($sformatf("%s_cnt0", name), {24'd0, reset_count}, {24'd0, exp_cnt});
      clear_lockout = (k == clear_at);
      if (k == release_at) force_reset = 1'b0;
      if (pulse_at >= 0) begin
        if (k == pulse_at) force_reset = 1'b1;
        else if (k == pulse_at + 1) force_reset = 1'b0;
      end
      if (k == drop_enable_at) enable = 1'b0;
    end
    check_value($sformatf("%s_cnt_end", name), {24'd0, reset_count}, {24'd0, exp_cnt});
    $display("[%0t] %s: sequence observed, reset_count=%0d", $time, name, reset_count);
  endtask

  // From LOCKOUT: clear is sampled at edge M, settle runs M..M+7, done at M+8.
  task automatic clear_from_lockout(input string name);
    logic [3:0] exp;
    clear_lockout = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      clear_lockout = 1'b0;
      if (k < 8)       exp = S_WAIT;
      else if (k == 8) exp = S_DONE;
      else             exp = S_QUIET;
      check_value($sformatf("%s_k%0d", name, k), {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, exp});
    end
    check_value($sformatf("%s_cnt", name), {24'd0, reset_count}, 32'd0);
    $display("[%0t] %s: lockout cleared, reset_count=%0d", $time, name, reset_count);
  endtask

  task automatic expect_quiet(input string name, input int cycles, input logic [7:0] exp_cnt);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_value($sformatf("%s_k%0d", name, k), {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, S_QUIET});
    end
    check_value($sformatf("%s_cnt", name), {24'd0, reset_count}, {24'd0, exp_cnt});
    $display("[%0t] %s: idle as expected, reset_count=%0d", $time, name, reset_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not complete in time");
  end

  initial begin
    // Reset with force_reset already high: the release must not trigger.
    rst           = 1'b1;
    enable        = 1'b1;
    force_reset   = 1'b1;
    clear_lockout = 1'b0;
    repeat (2) @(negedge clk);
    check_value("reset_status", {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, S_QUIET});
    check_value("reset_count", {24'd0, reset_count}, 32'd0);
    rst = 1'b0;
    expect_quiet("held_through_reset", 4, 8'd0);
    force_reset = 1'b0;
    @(negedge clk);

    // Single event.
    force_reset = 1'b1;
    run_seq("single", 8'd1, 1'b0, 1, -1, -1, -1);

    // Clear in idle.
    clear_lockout = 1'b1;
    @(negedge clk);
    clear_lockout = 1'b0;
    check_value("idle_clear_cnt", {24'd0, reset_count}, 32'd0);
    $display("[%0t] idle_clear: reset_count=%0d", $time, reset_count);

    // Level held for 40 cycles: exactly one sequence.
    force_reset = 1'b1;
    run_seq("held", 8'd1, 1'b0, -1, -1, -1, -1);
    expect_quiet("held_tail", 14, 8'd1);
    force_reset = 1'b0;
    @(negedge clk);

    // Second edge during SETTLE ignored.
    force_reset = 1'b1;
    run_seq("settle_edge", 8'd2, 1'b0, 2, 18, -1, -1);

    // Lockout after four events; clear pulses in ASSERT/SETTLE ignored.
    clear_lockout = 1'b1;
    @(negedge clk);
    clear_lockout = 1'b0;
    force_reset = 1'b1;
    run_seq("lock_ev1", 8'd1, 1'b0, 1, -1, -1, -1);
    force_reset = 1'b1;
    run_seq("lock_ev2", 8'd2, 1'b0, 1, -1, -1, 3);
    force_reset = 1'b1;
    run_seq("lock_ev3", 8'd3, 1'b0, 1, -1, -1, 20);
    force_reset = 1'b1;
    run_seq("lock_ev4", 8'd4, 1'b1, 1, -1, -1, -1);
    force_reset = 1'b1;
    @(negedge clk);
    force_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_value("lock_hold", {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, S_LOCK});
    check_value("lock_edge_cnt", {24'd0, reset_count}, 32'd4);
    clear_from_lockout("lock_clear");

    // Enable gating.
    enable = 1'b0;
    force_reset = 1'b1;
    expect_quiet("gated", 5, 8'd0);
    force_reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    force_reset = 1'b1;
    run_seq("enable_drop", 8'd1, 1'b0, 1, -1, 4, -1);
    enable = 1'b1;

    // Async reset mid-ASSERT, request held through release.
    force_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value($sformatf("abort_k%0d", k), {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, S_HOLD});
    end
    check_value("abort_cnt_before", {24'd0, reset_count}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_value("abort_async_status", {28'd0, sys_rst, busy, rst_done, lockout}, {28'd0, S_QUIET});
    check_value("abort_async_cnt", {24'd0, reset_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("abort_release", 4, 8'd0);
    force_reset = 1'b0;
    @(negedge clk);
    $display("[%0t] abort: async reset honoured", $time);

    // Saturation at 255.
    force dut.count_reg = 8'd255;
    @(negedge clk);
    release dut.count_reg;
    @(negedge clk);
    check_value("sat_preload", {24'd0, reset_count}, 32'd255);
    force_reset = 1'b1;
    run_seq("sat", 8'd255, 1'b1, 1, -1, -1, -1);
    clear_from_lockout("sat_clear");

    // Clear and trigger together in idle.
    force_reset = 1'b1;
    run_seq("pre_coincide", 8'd1, 1'b0, 1, -1, -1, -1);
    force_reset   = 1'b1;
    clear_lockout = 1'b1;
    run_seq("coincide", 8'd1, 1'b0, 1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
